// File: rtl/and_mux_pkg.sv
// rtl/and_mux_pkg.sv - mode encoding and the mux-form lane function for and_mux_lanes
package and_mux_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_ANDN = 2'd2,
    MODE_PASS = 2'd3
  } mode_t;

  // Widest lane lane_f can evaluate; callers zero-extend operands and truncate the result.
  localparam int unsigned LANE_W_MAX = 64;

  // Every result bit is a 2:1 mux selected by a; MODE_PASS keeps the data arm non-constant.
  function automatic logic [LANE_W_MAX-1:0] lane_f(
    input mode_t                 mode,
    input logic [LANE_W_MAX-1:0] a,
    input logic [LANE_W_MAX-1:0] b
  );
    logic [LANE_W_MAX-1:0] r;
    r = '0;
    for (int k = 0; k < LANE_W_MAX; k++) begin
      case (mode)
        MODE_AND:  r[k] = a[k] ? b[k] : 1'b0;
        MODE_OR:   r[k] = a[k] ? 1'b1 : b[k];
        MODE_ANDN: r[k] = a[k] ? 1'b0 : b[k];
        default:   r[k] = a[k] ? a[k] : b[k];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/and_mux_skid.sv
// rtl/and_mux_skid.sv - output register plus one skid register with registered in_ready
module and_mux_skid #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          or_valid_q, or_valid_d;
  logic [PW-1:0] or_data_q, or_data_d;
  logic          sk_valid_q, sk_valid_d;
  logic [PW-1:0] sk_data_q, sk_data_d;
  logic          in_ready_q, in_ready_d;
  logic          acc, pop;

  assign acc = in_valid & in_ready_q;
  assign pop = or_valid_q & out_ready;

  // Next-state: OR refills from SK first so ordering stays FIFO; SK only catches beats while OR is stuck.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    if (!or_valid_q || pop) begin
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        sk_valid_d = acc;
        if (acc) sk_data_d = in_data;
      end else begin
        or_valid_d = acc;
        if (acc) or_data_d = in_data;
      end
    end else if (acc) begin
      sk_valid_d = 1'b1;
      sk_data_d  = in_data;
    end
    in_ready_d = ~sk_valid_d;
  end

  // State registers; reset drops both stages at once and reopens the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;

endmodule

// File: rtl/and_mux_lanes.sv
// rtl/and_mux_lanes.sv - pipelined multi-lane mux-gated datapath; optional stats via AND_MUX_LANES_STATS_EN
module and_mux_lanes
  import and_mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LANES   = 4,
  parameter int unsigned STATS_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  mode_t                  in_mode,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic [LANES-1:0]       out_zero,
  output logic [STATS_W-1:0]     stat_beats,
  output logic [STATS_W-1:0]     stat_zero
);

  localparam int unsigned PW = LANES*WIDTH + LANES;

  logic [LANES*WIDTH-1:0] y_c;
  logic [LANES-1:0]       zero_c;
  logic [PW-1:0]          out_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign y_c[i*WIDTH +: WIDTH] = WIDTH'(lane_f(in_mode,
                                                 LANE_W_MAX'(in_a[i*WIDTH +: WIDTH]),
                                                 LANE_W_MAX'(in_b[i*WIDTH +: WIDTH])));
    assign zero_c[i] = ~|y_c[i*WIDTH +: WIDTH];
  end

  and_mux_skid #(.PW(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({y_c, zero_c}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_y    = out_data[PW-1:LANES];
  assign out_zero = out_data[LANES-1:0];

`ifdef AND_MUX_LANES_STATS_EN
  logic               acc;
  logic [STATS_W-1:0] beats_q, beats_d;
  logic [STATS_W-1:0] zero_q, zero_d;

  assign acc = in_valid & in_ready;

  // Saturating counters: accepted beats, and accepted beats whose every lane is zero.
  always_comb begin
    beats_d = beats_q;
    zero_d  = zero_q;
    if (acc) begin
      if (~&beats_q) beats_d = beats_q + 1'b1;
      if ((&zero_c) && (~&zero_q)) zero_d = zero_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
      zero_q  <= '0;
    end else begin
      beats_q <= beats_d;
      zero_q  <= zero_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_zero  = zero_q;
`else
  assign stat_beats = '0;
  assign stat_zero  = '0;
`endif

endmodule

// File: tb/tb_and_mux_lanes.sv
// tb/tb_and_mux_lanes.sv - directed and random self-checking bench for and_mux_lanes
module tb_and_mux_lanes;
  import and_mux_pkg::*;

`ifdef AND_MUX_LANES_STATS_EN
  localparam int SW = 4;
  localparam bit STATS_ON = 1'b1;
`else
  localparam int SW = 16;
  localparam bit STATS_ON = 1'b0;
`endif
  localparam int MAXS = (1 << SW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  mode_t       in_mode;
  logic [31:0] in_a, in_b, out_y;
  logic [3:0]  out_zero;
  logic [SW-1:0] stat_beats, stat_zero;

  int tests = 0;
  int fails = 0;
  int tot_acc = 0;

  always #5 clk = ~clk;

  and_mux_lanes #(.WIDTH(8), .LANES(4), .STATS_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_zero   (out_zero),
    .stat_beats (stat_beats),
    .stat_zero  (stat_zero)
  );

  function automatic logic [31:0] ref_y(input mode_t m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      MODE_AND:  return a & b;
      MODE_OR:   return a | b;
      MODE_ANDN: return ~a & b;
      default:   return a | b;
    endcase
  endfunction

  function automatic logic [3:0] ref_zero(input logic [31:0] y);
    logic [3:0] z;
    for (int i = 0; i < 4; i++) z[i] = (y[i*8 +: 8] == 8'h00);
    return z;
  endfunction

  function automatic int sat(input int n);
    return (n > MAXS) ? MAXS : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count the accept happening at the coming edge, then step to just after it.
  task automatic cycle();
    if (in_valid && in_ready && rst_n) tot_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mode_t m, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
  endtask

  logic [35:0] q[$];
  logic [35:0] e;
  logic [31:0] ra, rb, held_y;
  logic [3:0]  held_z;
  mode_t       rm;
  bit          hold;
  int          sent;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = MODE_AND; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset then idle
    cycle();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_stat_beats", stat_beats, 0);
    chk("rst_stat_zero", stat_zero, 0);

    // mode sweep, one-cycle latency
    out_ready = 1'b1;
    drive(MODE_AND, 32'hF0F0_FF00, 32'hAAAA_5555); cycle();
    chk("and_valid", out_valid, 1);
    chk("and_y", out_y, 32'hA0A0_5500);
    chk("and_zero", out_zero, 4'b0001);
    drive(MODE_OR, 32'hF0F0_FF00, 32'hAAAA_5555); cycle();
    chk("or_y", out_y, 32'hFAFA_FF55);
    chk("or_zero", out_zero, 4'b0000);
    drive(MODE_ANDN, 32'hF0F0_FF00, 32'hAAAA_5555); cycle();
    chk("andn_y", out_y, 32'h0A0A_0055);
    chk("andn_zero", out_zero, 4'b0010);
    drive(MODE_PASS, 32'hF0F0_FF00, 32'hAAAA_5555); cycle();
    chk("pass_y", out_y, 32'hFAFA_FF55);
    chk("pass_valid", out_valid, 1);

    // zero flags
    drive(MODE_AND, 32'h00FF_0000, 32'hFFFF_FFFF); cycle();
    chk("zf_y", out_y, 32'h00FF_0000);
    chk("zf_zero", out_zero, 4'b1011);
    chk("zf_stat_zero0", stat_zero, 0);
    drive(MODE_AND, 32'h0000_0000, 32'hFFFF_FFFF); cycle();
    chk("zf_zero_all", out_zero, 4'b1111);
    chk("zf_stat_zero1", stat_zero, STATS_ON ? 1 : 0);
    in_valid = 1'b0; cycle();
    chk("idle_valid", out_valid, 0);
    chk("stat_beats6", stat_beats, STATS_ON ? sat(6) : 0);

    // backpressure: beat1 in OR, beat2 in SK, beat3 stalls
    out_ready = 1'b0;
    drive(MODE_AND, 32'hFFFF_FFFF, 32'h1111_1111); cycle();
    chk("bp_b1_y", out_y, 32'h1111_1111);
    chk("bp_b1_ready", in_ready, 1);
    drive(MODE_AND, 32'hFFFF_FFFF, 32'h2222_2222); cycle();
    chk("bp_b2_ready", in_ready, 0);
    chk("bp_b2_hold", out_y, 32'h1111_1111);
    drive(MODE_AND, 32'hFFFF_FFFF, 32'h3333_3333); cycle();
    chk("bp_b3_stall", in_ready, 0);
    chk("bp_b3_hold", out_y, 32'h1111_1111);
    chk("bp_valid", out_valid, 1);
    out_ready = 1'b1; cycle();
    chk("bp_d2", out_y, 32'h2222_2222);
    chk("bp_ready_back", in_ready, 1);
    cycle();
    chk("bp_d3", out_y, 32'h3333_3333);
    in_valid = 1'b0; cycle();
    chk("bp_empty", out_valid, 0);
    chk("stat_beats9", stat_beats, STATS_ON ? sat(9) : 0);

    // random valid/ready against a scoreboard
    sent = 0; hold = 1'b0;
    for (int cyc = 0; cyc < 20000 && (sent < 2000 || q.size() > 0); cyc++) begin
      if (sent < 2000 && $urandom_range(0, 3) != 0) begin
        ra = $urandom; rb = $urandom;
        if ($urandom_range(0, 3) == 0) ra = ra & 32'h00FF_00FF;
        rm = mode_t'($urandom_range(0, 3));
        drive(rm, ra, rb);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back({ref_y(in_mode, in_a, in_b), ref_zero(ref_y(in_mode, in_a, in_b))});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("rand_y", out_y, e[35:4]);
          chk("rand_zero", out_zero, e[3:0]);
        end
      end
      hold = out_valid && !out_ready;
      held_y = out_y; held_z = out_zero;
      cycle();
      if (hold) chk("rand_hold", {out_valid, out_zero, out_y}, {1'b1, held_z, held_y});
    end
    in_valid = 1'b0;
    chk("rand_drain", q.size() + (2000 - sent), 0);
    chk("rand_stat_beats", stat_beats, STATS_ON ? sat(tot_acc) : 0);

    // asynchronous reset with OR and SK full
    out_ready = 1'b0;
    drive(MODE_OR, 32'h0000_0001, 32'h0000_0000); cycle();
    drive(MODE_OR, 32'h0000_0002, 32'h0000_0000); cycle();
    chk("mr_full_valid", out_valid, 1);
    chk("mr_full_ready", in_ready, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_y", out_y, 0);
    chk("mr_stat_beats", stat_beats, 0);
    @(negedge clk) rst_n = 1'b1;
    tot_acc = 0;
    @(posedge clk); #1;
    chk("mr_after_valid", out_valid, 0);

    // saturation: 20 beats
    out_ready = 1'b1;
    drive(MODE_AND, 32'hFFFF_FFFF, 32'h0102_0304);
    repeat (20) cycle();
    in_valid = 1'b0; cycle();
    chk("sat_stat_beats", stat_beats, STATS_ON ? sat(tot_acc) : 0);
    chk("sat_count", tot_acc, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
